// File: rtl/fak65xx_bank_mapper.sv
// 6509-style bank mapper: execution/indirect bank registers plus an
// indirect-indexed cycle tracker that steers the upper address lines.
module fak65xx_bank_mapper #(
  parameter int unsigned           BANK_WIDTH = 4,
  parameter logic [15:0]           REG_BASE   = 16'h0000,
  parameter logic [BANK_WIDTH-1:0] EXEC_RESET = '1,
  parameter logic [BANK_WIDTH-1:0] IND_RESET  = '1,
  parameter bit                    CMOS_IND   = 1'b0
) (
  input  logic                  clock,
  input  logic                  _reset,
  input  logic                  phi2,
  input  logic                  r_w,
  input  logic [15:0]           address_cpu,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  data_oe,
  input  logic                  rdy,
  input  logic                  sync,
  output logic [BANK_WIDTH-1:0] address_bank,
  output logic                  ind_active
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_C2   = 3'd1,
    ST_C3   = 3'd2,
    ST_C4   = 3'd3,
    ST_C5   = 3'd4,
    ST_C6   = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic                  cmos_q, cmos_d;
  logic [BANK_WIDTH-1:0] exec_q, ind_q;

  logic hit, sel, adv, op_nmos, op_cmos, match;

  assign hit = (address_cpu[15:1] == REG_BASE[15:1]);
  assign sel = address_cpu[0];
  // Writes always complete; only RDY-stretched reads hold the sequence.
  assign adv = rdy | ~r_w;

  assign op_nmos = (data_in == 8'hB1) || (data_in == 8'h91);
  assign op_cmos = CMOS_IND && ((data_in == 8'hB2) || (data_in == 8'h92));
  assign match   = sync & adv & (op_nmos | op_cmos);

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      exec_q <= EXEC_RESET;
      ind_q  <= IND_RESET;
    end else if (hit && !r_w) begin
      if (sel) ind_q  <= data_in[BANK_WIDTH-1:0];
      else     exec_q <= data_in[BANK_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state_q <= ST_IDLE;
      cmos_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmos_q  <= cmos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmos_d  = cmos_q;
    if (adv) begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_C2:   state_d = ST_C3;
        ST_C3:   state_d = ST_C4;
        ST_C4:   state_d = ST_C5;
        // (zp) forms are one cycle shorter: no extra indirect cycle.
        ST_C5:   state_d = cmos_q ? ST_IDLE : ST_C6;
        ST_C6:   state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    if (match) begin
      state_d = ST_C2;
      cmos_d  = op_cmos;
    end
  end

  // In C6 a SYNC means LDA finished without a page cross: back to exec bank.
  assign ind_active   = (state_q == ST_C5) || ((state_q == ST_C6) && !sync);
  assign address_bank = ind_active ? ind_q : exec_q;

  always_comb begin
    data_out = 8'hFF;
    data_out[BANK_WIDTH-1:0] = sel ? ind_q : exec_q;
  end

  assign data_oe = hit & r_w & phi2;

endmodule
